// File: rtl/iob_reverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : iob_reverse_stream
// Brief    : Valid/ready stream stage that bit/symbol-reverses each word,
//            with a registered output and a one-word skid register.
// Revision : 1.0 - initial release
// ============================================================================
module iob_reverse_stream #(
    parameter int DATA_W   = 32,
    parameter int SYMBOL_W = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        mode_o,
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int c_NUM_SYM = DATA_W / SYMBOL_W;

    // Encoding is {valid, full}: valid_o and ready_o come straight off flops.
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b10;
    localparam logic [1:0] c_TWO   = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [1:0]        r_main_mode;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_skid_mode;

    logic [DATA_W-1:0] w_full_rev;
    logic [DATA_W-1:0] w_sym_swap;
    logic [DATA_W-1:0] w_sym_brev;
    logic [DATA_W-1:0] w_xform;

    logic w_acc;
    logic w_pop;
    logic w_load_main_new;
    logic w_load_main_skid;
    logic w_load_skid;

    for (genvar k = 0; k < DATA_W; k++) begin : g_full_rev
        assign w_full_rev[k] = data_i[DATA_W-1-k];
    end

    for (genvar s = 0; s < c_NUM_SYM; s++) begin : g_sym
        assign w_sym_swap[s*SYMBOL_W +: SYMBOL_W] =
            data_i[(c_NUM_SYM-1-s)*SYMBOL_W +: SYMBOL_W];
        for (genvar j = 0; j < SYMBOL_W; j++) begin : g_bit
            assign w_sym_brev[s*SYMBOL_W + j] = data_i[s*SYMBOL_W + SYMBOL_W - 1 - j];
        end
    end

    always_comb begin
        w_xform = data_i;
        case (mode_i)
            2'd1:    w_xform = w_full_rev;
            2'd2:    w_xform = w_sym_swap;
            2'd3:    w_xform = w_sym_brev;
            default: w_xform = data_i;
        endcase
    end

    assign valid_o = r_state[1];
    assign ready_o = ~r_state[0];
    assign data_o  = r_main_data;
    assign mode_o  = r_main_mode;

    assign w_acc = valid_i & ready_o & cke_i;
    assign w_pop = valid_o & ready_i & cke_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: if (w_acc) w_state_nxt = c_ONE;
            c_ONE: begin
                if (w_acc && !w_pop)      w_state_nxt = c_TWO;
                else if (!w_acc && w_pop) w_state_nxt = c_EMPTY;
            end
            c_TWO:   if (w_pop) w_state_nxt = c_ONE;
            default: w_state_nxt = c_EMPTY;
        endcase
    end

    always_comb begin
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            c_EMPTY: w_load_main_new = w_acc;
            c_ONE: begin
                w_load_main_new = w_acc & w_pop;
                w_load_skid     = w_acc & ~w_pop;
            end
            c_TWO:   w_load_main_skid = w_pop;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_main_data <= '0;
            r_main_mode <= 2'd0;
            r_skid_data <= '0;
            r_skid_mode <= 2'd0;
        end else begin
            if (w_load_main_new) begin
                r_main_data <= w_xform;
                r_main_mode <= mode_i;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_mode <= r_skid_mode;
            end
            if (w_load_skid) begin
                r_skid_data <= w_xform;
                r_skid_mode <= mode_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iob_reverse_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_reverse_stream
// Brief    : Self-checking bench; queue-based reference of the stream stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_reverse_stream;

    localparam int DATA_W   = 32;
    localparam int SYMBOL_W = 8;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              cke;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        mode_o;
    logic              valid_o;
    logic              ready_i;

    int vectors     = 0;
    int miscompares = 0;

    // Expected contents of the stage, oldest first: {mode, transformed data}
    logic [DATA_W+1:0] q[$];
    bit                acc_f;
    bit                pop_f;
    bit                count_pops = 1'b0;
    int                pops_seen  = 0;

    iob_reverse_stream #(.DATA_W(DATA_W), .SYMBOL_W(SYMBOL_W)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .mode_i   (mode_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .mode_o   (mode_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_xform(input logic [DATA_W-1:0] x,
                                                    input logic [1:0] m);
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] t;
        case (m)
            2'd0: r = x;
            2'd1: r = {<<{x}};
            2'd2: r = {<<SYMBOL_W{x}};
            default: begin
                t = {<<{x}};
                r = {<<SYMBOL_W{t}};
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge arst_n) q.delete();

    always @(negedge clk) begin
        if (!arst_n) begin
            check("rst_valid", 64'(valid_o), 64'(0));
            check("rst_ready", 64'(ready_o), 64'(1));
            check("rst_data",  64'(data_o),  64'(0));
            check("rst_mode",  64'(mode_o),  64'(0));
            acc_f = 1'b0;
            pop_f = 1'b0;
        end else begin
            check("valid_o", 64'(valid_o), 64'(q.size() > 0));
            check("ready_o", 64'(ready_o), 64'(q.size() < 2));
            if (q.size() > 0) begin
                check("data_o", 64'(data_o), 64'(q[0][DATA_W-1:0]));
                check("mode_o", 64'(mode_o), 64'(q[0][DATA_W+1:DATA_W]));
            end
            acc_f = valid_i && cke && (q.size() < 2);
            pop_f = ready_i && cke && (q.size() > 0);
            if (count_pops && valid_o && ready_i && cke) pops_seen++;
        end
    end

    always @(posedge clk) begin
        if (arst_n) begin
            if (pop_f) void'(q.pop_front());
            if (acc_f) q.push_back({mode_i, ref_xform(data_i, mode_i)});
        end
    end

    initial begin
        logic [DATA_W-1:0] lit [4];
        logic [DATA_W-1:0] frozen_d;
        logic [1:0]        frozen_m;
        int                idx;
        int                c;
        bit                accepted;

        lit[0] = 32'h12345678;
        lit[1] = 32'h1E6A2C48;
        lit[2] = 32'h78563412;
        lit[3] = 32'h482C6A1E;

        arst_n  = 1'b0;
        cke     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        mode_i  = 2'd0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'($urandom);
            ready_i = 1'($urandom);
            cke     = 1'($urandom);
            data_i  = $urandom;
            mode_i  = 2'($urandom);
            step();
        end
        cke     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        arst_n  = 1'b1;
        step();

        // Each mode on the reference word, back to back
        for (int m = 0; m < 4; m++) begin
            data_i  = 32'h12345678;
            mode_i  = 2'(m);
            valid_i = 1'b1;
            ready_i = 1'b1;
            step();
            check("mode_lit_data", 64'(data_o), 64'(lit[m]));
            check("mode_lit_mode", 64'(mode_o), 64'(m));
        end
        valid_i = 1'b0;
        step();
        step();

        // Back-pressure: words 1..8, downstream stalled for the first 3 cycles
        idx     = 1;
        c       = 0;
        valid_i = 1'b1;
        mode_i  = 2'd0;
        while (idx <= 8 && c < 40) begin
            data_i   = 32'(idx);
            ready_i  = (c >= 3);
            accepted = ready_o;
            step();
            if (accepted) idx++;
            if (c == 2) begin
                check("bp_two_accepted", 64'(idx), 64'(3));
                check("bp_ready_low", 64'(ready_o), 64'(0));
                check("bp_head_held", 64'(data_o), 64'(1));
            end
            c++;
        end
        check("bp_all_accepted", 64'(idx), 64'(9));
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) step();

        // Full rate: 64 random words with ready held high
        pops_seen  = 0;
        count_pops = 1'b1;
        for (int i = 0; i < 64; i++) begin
            valid_i = 1'b1;
            ready_i = 1'b1;
            data_i  = $urandom;
            mode_i  = 2'($urandom);
            step();
            check("full_rate_valid", 64'(valid_o), 64'(1));
        end
        valid_i = 1'b0;
        repeat (3) step();
        count_pops = 1'b0;
        check("full_rate_pops", 64'(pops_seen), 64'(64));

        // Clock enable low while two words are held
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = $urandom;
        mode_i  = 2'($urandom);
        step();
        data_i  = $urandom;
        mode_i  = 2'($urandom);
        step();
        check("cke_full", 64'(ready_o), 64'(0));
        frozen_d = data_o;
        frozen_m = mode_o;
        cke      = 1'b0;
        ready_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'($urandom);
            data_i  = $urandom;
            step();
            check("cke_frozen_data", 64'(data_o), 64'(frozen_d));
            check("cke_frozen_mode", 64'(mode_o), 64'(frozen_m));
            check("cke_frozen_valid", 64'(valid_o), 64'(1));
        end
        cke     = 1'b1;
        valid_i = 1'b0;
        repeat (3) step();

        // Asynchronous reset while holding two words
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = $urandom;
        step();
        data_i  = $urandom;
        step();
        valid_i = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_valid_now", 64'(valid_o), 64'(0));
        check("arst_ready_now", 64'(ready_o), 64'(1));
        step();
        arst_n  = 1'b1;
        data_i  = 32'hA5A5A5A5;
        mode_i  = 2'd1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        step();
        check("post_rst_data", 64'(data_o), 64'(32'hA5A5A5A5));
        check("post_rst_mode", 64'(mode_o), 64'(1));
        valid_i = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            cke     = ($urandom_range(0, 7) != 0);
            data_i  = $urandom;
            mode_i  = 2'($urandom);
            step();
        end
        cke     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iob_reverse_stream.md
# iob_reverse_stream

Streaming, parametrised bit/symbol reversal unit with valid/ready handshakes and a two-entry skid buffer. Each accepted word is transformed by a per-word mode: pass-through, full bit reverse, symbol-order reverse (endian swap), or bit reverse inside each symbol. The result is registered on the output. The block sits between cache front-end/back-end datapaths and memory interfaces of differing endianness or bit ordering, and sustains one word per cycle under back-pressure.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of SYMBOL_W.
- SYMBOL_W, 8, symbol (lane) width in bits used by modes 2 and 3; 1 <= SYMBOL_W <= DATA_W.

Ports:
- clk_i  input  1  clock; all state is updated on the rising edge.
- arst_n_i  input  1  reset, asynchronous and active-low.
- cke_i  input  1  clock enable; when low, all state holds and no handshake completes.
- mode_i  input  2  transform for the word presented on data_i (0 pass, 1 full bit reverse, 2 symbol-order reverse, 3 per-symbol bit reverse).
- data_i  input  DATA_W  input word.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  DATA_W  transformed output word.
- mode_o  output  2  mode that was applied to data_o.
- valid_o  output  1  data_o/mode_o valid.
- ready_i  input  1  downstream accepts the word this cycle.

## Operation
- Input handshake (acc) = valid_i & ready_o & cke_i. Output handshake (pop) = valid_o & ready_i & cke_i.
- The transform is combinational on data_i/mode_i. Only the transformed word and its mode are stored.
  - Mode 0: out = in.
  - Mode 1: out[k] = in[DATA_W-1-k].
  - Mode 2: symbol s of out = symbol (N-1-s) of in, where N = DATA_W/SYMBOL_W. Bit order inside each symbol is preserved.
  - Mode 3: within each symbol, bit j of out = bit (SYMBOL_W-1-j) of in. Symbol order is preserved.
  - When SYMBOL_W == DATA_W: mode 2 equals mode 0 and mode 3 equals mode 1. When SYMBOL_W == 1: mode 2 equals mode 1 and mode 3 equals mode 0.
- Storage is a main register (drives outputs) and a skid register. The state machine uses occupancy:
  - EMPTY: valid_o=0, ready_o=1. On acc, load main and go to ONE.
  - ONE: valid_o=1, ready_o=1.
    - acc & pop: load main with the new word, stay in ONE.
    - acc & !pop: load skid, go to TWO.
    - !acc & pop: go to EMPTY.
  - TWO: valid_o=1, ready_o=0.
    - pop: move skid to main, go to ONE.
    - No acc is possible in TWO.
- ready_o and valid_o are driven directly from state registers. There is no combinational path from ready_i to ready_o or from valid_i to valid_o.
- Ordering is strict FIFO; no word is dropped or duplicated.
- data_o/mode_o hold their value while valid_o=1 and ready_i=0.
- cke_i low freezes state, data and outputs, regardless of valid_i/ready_i.
- arst_n_i low mid-operation discards all stored words immediately (asynchronously).

## Timing
- Reset values: valid_o=0, ready_o=1, data_o=0, mode_o=0, state EMPTY.
- Latency: a word accepted at edge n is presented on data_o after edge n (1 cycle) when the block is in EMPTY or ONE with a simultaneous pop.
- Throughput: 1 word/cycle with ready_i held high.
- ready_o falls one cycle after the first stalled accept in ONE. It rises one cycle after the pop that leaves TWO.
- First accept is possible on the first enabled edge after arst_n_i deasserts.

## Test plan
- Reset: hold arst_n_i=0 with random inputs -> valid_o=0, ready_o=1, data_o=0, mode_o=0.
- Modes (DATA_W=32, SYMBOL_W=8), data_i=0x12345678, ready_i=1:
  - mode 0 -> 0x12345678
  - mode 1 -> 0x1E6A2C48
  - mode 2 -> 0x78563412
  - mode 3 -> 0x482C6A1E
  - Each result appears one cycle after accept, with mode_o matching.
- Back-pressure: stream 0x1..0x8 (mode 0) with ready_i=0 for 3 cycles. Expect:
  - Two words are accepted, then ready_o=0.
  - data_o stays 0x1.
  - After ready_i=1, outputs are 0x1..0x8 in order with no gaps once steady.
- Full-rate: valid_i=ready_i=1 for 64 random words/modes -> 64 outputs, each equal to the reference model, with one output per cycle.
- cke_i: in state TWO, drop cke_i for 5 cycles with ready_i=1 -> no pop, outputs frozen. On cke_i=1, the stored words drain in order.
- Reset mid-stream: assert arst_n_i in TWO -> valid_o=0 and ready_o=1 immediately. After release, the next word 0xA5A5A5A5 (mode 1) emerges as 0xA5A5A5A5.
